// File: rtl/alu_cmd_sequencer.sv
// Command-to-ALU sequencer: registers operands for a combinational ALU, captures the result a
// cycle later and returns it on a valid/ready response stream. Define ALU_SEQ_CHECK_EN for checker.
module alu_cmd_sequencer #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned OP_CNT_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [DATA_W-1:0]   cmd_a_i,
  input  logic [DATA_W-1:0]   cmd_b_i,
  input  logic [1:0]          cmd_op_i,
  output logic [DATA_W-1:0]   alu_a_o,
  output logic [DATA_W-1:0]   alu_b_o,
  output logic [1:0]          alu_opcode_o,
  input  logic [DATA_W-1:0]   alu_result_i,
  input  logic                alu_zero_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_result_o,
  output logic                rsp_zero_o,
  output logic [OP_CNT_W-1:0] op_count_o,
  output logic                chk_err_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     alu_a_q, alu_a_d;
  logic [DATA_W-1:0]     alu_b_q, alu_b_d;
  logic [1:0]            alu_op_q, alu_op_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_result_q, rsp_result_d;
  logic                  rsp_zero_q, rsp_zero_d;
  logic [OP_CNT_W-1:0]   op_count_q, op_count_d;
  logic                  accept;

  // A command may be taken in the same cycle the pending response is consumed.
  assign cmd_ready_o = (state_q == StIdle) || ((state_q == StResp) && rsp_ready_i);
  assign accept      = cmd_valid_i && cmd_ready_o;

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    op_count_d   = op_count_q;
    if (accept) begin
      alu_a_d  = cmd_a_i;
      alu_b_d  = cmd_b_i;
      alu_op_d = cmd_op_i;
    end
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StIssue;
      end
      StIssue: begin
        rsp_result_d = alu_result_i;
        rsp_zero_d   = alu_zero_i;
        rsp_valid_d  = 1'b1;
        state_d      = StResp;
      end
      StResp: begin
        if (rsp_ready_i) begin
          op_count_d  = op_count_q + 1'b1;
          rsp_valid_d = 1'b0;
          state_d     = accept ? StIssue : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= 2'b00;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      op_count_q   <= op_count_d;
    end
  end

  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_opcode_o = alu_op_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_zero_o   = rsp_zero_q;
  assign op_count_o   = op_count_q;

`ifdef ALU_SEQ_CHECK_EN
  logic [DATA_W-1:0] exp_result;
  logic              exp_zero;
  logic              chk_err_q, chk_err_d;

  always_comb begin
    case (alu_op_q)
      2'b00:   exp_result = alu_a_q + alu_b_q;
      2'b01:   exp_result = alu_a_q - alu_b_q;
      2'b10:   exp_result = alu_a_q & alu_b_q;
      default: exp_result = alu_a_q | alu_b_q;
    endcase
    exp_zero  = (exp_result == '0);
    chk_err_d = chk_err_q;
    // Only ISSUE samples the ALU, so only there is a mismatch meaningful.
    if ((state_q == StIssue) && ((exp_result != alu_result_i) || (exp_zero != alu_zero_i))) begin
      chk_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) chk_err_q <= 1'b0;
    else       chk_err_q <= chk_err_d;
  end

  assign chk_err_o = chk_err_q;
`else
  assign chk_err_o = 1'b0;
`endif

endmodule
